// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port data memory: fixed CPU priority with a starvation-forced DMA slot.
// Optional performance counters are enabled with the DMEM_ARB_PERF_EN macro.
module dmem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [2:0]    sel0,
  input  logic [AW-1:0] addr0,
  input  logic [31:0]   wd0,
  output logic          gnt0,
  output logic          cpu_stall,
  input  logic          req1,
  input  logic          we1,
  input  logic [2:0]    sel1,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wd1,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          write_enable_dmem,
  output logic [2:0]    store_sel_M,
  output logic [2:0]    load_sel_M,
  output logic [31:0]   mem_WA,
  output logic [31:0]   mem_WD,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]   perf_conflicts,
  output logic [31:0]   perf_forced,
  output logic [31:0]   perf_rejects,
`endif
  input  logic [31:0]   mem_RD
);

  localparam int unsigned CW = 8;

  typedef enum logic [0:0] {CPU_PRI, DMA_FORCE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;

  logic          granted;
  logic          sel_we;
  logic [2:0]    sel_sz;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wd;
  logic          legal;
  logic          aligned;
  logic          rejected;

  // State and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CPU_PRI;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Grant decision and next-state / counter logic
  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      CPU_PRI: begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
      end
      DMA_FORCE: begin
        gnt1 = req1;
        gnt0 = ~req1 & req0;
      end
      default: ;
    endcase
    if (state == DMA_FORCE) begin
      state_next    = CPU_PRI;
      wait_cnt_next = '0;
    end else if (req1 & ~gnt1) begin
      if (wait_cnt == CW'(MAX_WAIT - 1)) state_next = DMA_FORCE;
      if (wait_cnt != '1) wait_cnt_next = wait_cnt + CW'(1);
    end else begin
      wait_cnt_next = '0;
    end
  end

  assign cpu_stall = req0 & ~gnt0;
  assign granted   = gnt0 | gnt1;

  // Port 0 drives memory whenever port 1 is not granted
  assign sel_we   = gnt1 ? we1   : we0;
  assign sel_sz   = gnt1 ? sel1  : sel0;
  assign sel_addr = gnt1 ? addr1 : addr0;
  assign sel_wd   = gnt1 ? wd1   : wd0;

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    case (sel_sz)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~sel_we;
      default:                legal = 1'b0;
    endcase
    case (sel_sz)
      3'b001, 3'b101: aligned = ~sel_addr[0];
      3'b010:         aligned = (sel_addr[1:0] == 2'b00);
      default:        aligned = 1'b1;
    endcase
  end

  assign rejected          = ~(legal & aligned);
  assign write_enable_dmem = granted & sel_we & ~rejected;
  assign store_sel_M       = sel_sz;
  assign load_sel_M        = sel_sz;
  assign mem_WA            = 32'(sel_addr);
  assign mem_WD            = sel_wd;

  // Registered response, one cycle after the grant
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      if (granted) begin
        err   <= rejected;
        rdata <= (sel_we | rejected) ? 32'h0 : mem_RD;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflicts <= '0;
      perf_forced    <= '0;
      perf_rejects   <= '0;
    end else begin
      if (req0 && req1 && perf_conflicts != '1) perf_conflicts <= perf_conflicts + 32'(1);
      if (state == DMA_FORCE && gnt1 && perf_forced != '1) perf_forced <= perf_forced + 32'(1);
      if (granted && rejected && perf_rejects != '1) perf_rejects <= perf_rejects + 32'(1);
    end
  end
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (port 0, CPU) and a DMA/debug loader (port 1).
- Sits between both requesters and the data memory. Drives the memory's write enable, store/load select, address and write data; samples its read data.
- Port 0 has fixed priority. A starvation counter guarantees port 1 a slot.
- Rejects misaligned or illegal-size accesses before they reach memory.

Parameters:
- MAX_WAIT, 4, consecutive denied cycles of port 1 before it is force-granted one slot (range 1..255).
- AW, 32, address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req0  input  1  CPU request
- we0  input  1  CPU write (1) / read (0)
- sel0  input  3  CPU size code
- addr0  input  AW  CPU byte address
- wd0  input  32  CPU write data
- gnt0  output  1  CPU granted this cycle
- cpu_stall  output  1  req0 & ~gnt0
- req1  input  1  DMA request
- we1  input  1  DMA write/read
- sel1  input  3  DMA size code
- addr1  input  AW  DMA byte address
- wd1  input  32  DMA write data
- gnt1  output  1  DMA granted this cycle
- rvalid0  output  1  CPU response valid
- rvalid1  output  1  DMA response valid
- rdata  output  32  read data of completed access (shared)
- err  output  1  completed access was misaligned or illegal
- write_enable_dmem  output  1  memory write enable
- store_sel_M  output  3  memory store select
- load_sel_M  output  3  memory load select
- mem_WA  output  32  memory address (zero-extended from AW)
- mem_WD  output  32  memory write data
- mem_RD  input  32  memory read data (combinational from mem_WA/load_sel_M)

Behaviour:
- Size codes:
  - 000 byte, 001 half, 010 word: loads sign-extend; the same codes are the stores.
  - 100 byte-unsigned, 101 half-unsigned: loads only.
  - Any other code is illegal.
- Writes may only use codes 000/001/010; a write with 100/101 is illegal.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=00.
- FSM states:
  - CPU_PRI (reset state): gnt0=req0; gnt1=req1 & ~req0.
  - DMA_FORCE: gnt1=req1; gnt0=~req1 & req0.
- FSM transitions:
  - CPU_PRI -> DMA_FORCE when wait_cnt reaches MAX_WAIT-1 and a further denial occurs (req1 & ~gnt1).
  - DMA_FORCE -> CPU_PRI after exactly one cycle, regardless of req1.
- wait_cnt (8 bit):
  - +1 each cycle with req1 & ~gnt1.
  - Cleared on gnt1, on ~req1, and on entry to CPU_PRI from DMA_FORCE.
  - Saturates; never wraps.
- Memory drive (combinational, same cycle as the grant):
  - mem_WA/mem_WD/store_sel_M/load_sel_M come from the granted port.
  - If no port is granted, they come from port 0.
  - write_enable_dmem = granted & we & legal & aligned.
  - A rejected access never writes memory and never reaches memory with write enabled.
- Response (registered):
  - On the clock edge ending a granted cycle, capture rdata <= mem_RD for reads, or 0 for writes and rejected accesses.
  - err <= rejected.
  - rvalid0 <= gnt0; rvalid1 <= gnt1.
  - Latency: one cycle after grant. rvalid pulses exactly one cycle; a response is produced for writes too.
- Back-to-back grants to the same port are allowed on consecutive cycles, with no bubble.
- gnt0 and gnt1 are never both 1.
- Reset:
  - All registered outputs are 0 (rvalid0, rvalid1, rdata, err); state=CPU_PRI; wait_cnt=0.
  - Reset during a granted cycle: the write still occurs, because memory sees write_enable_dmem that cycle. The response is suppressed; the registers take reset values.
  - Grants are combinational and therefore follow the request inputs even while rst=1. Requesters must hold req low during reset.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined, adds three 32-bit outputs, cleared on rst and saturating at 32'hFFFFFFFF:
  - perf_conflicts: cycles with req0 & req1.
  - perf_forced: DMA_FORCE cycles with gnt1.
  - perf_rejects: rejected grants.
- When undefined, these ports and counters are absent, and the other ports and their behaviour are unchanged.

Test Plan:
- Hold req1=1 with addr1=0x40, we1=0, sel1=010, with req0 idle -> gnt1=1 same cycle; next cycle rvalid1=1, rdata=mem word at 0x40, err=0.
- Hold req0 and req1 continuously with MAX_WAIT=4 -> gnt0 for 4 cycles, gnt1 on the 5th with cpu_stall=1 that cycle, then gnt0 resumes. Pattern repeats every 5 cycles.
- CPU write sel0=000, addr0=0x103, wd0=0xA5 -> store_sel_M=000, mem_WA=0x103, write_enable_dmem=1. A later read sel0=100 at 0x103 -> rdata=0x000000A5; sel0=000 -> 0xFFFFFFA5.
- CPU write sel0=010 at addr0=0x102 -> write_enable_dmem=0; next cycle rvalid0=1, err=1, rdata=0; the memory word is unchanged.
- DMA write sel1=101 at 0x200 -> write_enable_dmem=0, err=1. DMA read sel1=111 -> err=1.
- Assert rst for one cycle while req1 is denied and wait_cnt=3 -> after reset, state=CPU_PRI, wait_cnt=0, rvalid0/1=0, rdata=0. With both requesters held active, the forced DMA slot next arrives 5 cycles after reset release.
